request_unit: RTL and testbench
===============================

REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 Block SHALL have no parameters; data and address buses are fixed at 32 bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 i_ready  input  1  instruction memory hit; current instruction valid.
REQ-005 d_ready  input  1  data memory access complete.
REQ-006 cuOP  input  cuOPType  control-unit opcode (codebase enum).
REQ-007 dmmstorei / dmmaddri / imemaddri  input  32 each  store data, data address, instruction address from datapath.
REQ-008 imemloadi / dmmloadi  input  32 each  instruction word and load data from memory.
REQ-009 dmmRen / dmmWen  output  1 each  registered data read/write request.
REQ-010 imemRen  output  1  instruction fetch request.
REQ-011 dmmstoreo / dmmaddro / imemaddro  output  32 each  store data, data address, instruction address to memory.
REQ-012 imemloado / dmmloado  output  32 each  instruction word and load data to datapath.

Function
REQ-013 Load class SHALL be CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU; store class SHALL be CU_SB, CU_SH, CU_SW; every other cuOP value is non-memory.
REQ-014 At each rising CLK with nRST=1 and d_ready=1, dmmRen and dmmWen SHALL both become 0 (d_ready wins over i_ready).
REQ-015 Else, with i_ready=1, dmmRen SHALL become 1 iff cuOP is load class and dmmWen SHALL become 1 iff cuOP is store class; a non-memory cuOP clears both.
REQ-016 Else, with i_ready=0 and d_ready=0, dmmRen and dmmWen SHALL hold.
REQ-017 dmmRen and dmmWen SHALL never be 1 in the same cycle.
REQ-018 imemRen SHALL be combinational: 1 when dmmRen=0 and dmmWen=0, else 0.
REQ-019 Request latency SHALL be one cycle: dmmRen/dmmWen rise on the first rising edge after i_ready is sampled high with a memory cuOP.
REQ-020 imemaddro SHALL equal imemaddri, imemloado SHALL equal imemloadi, and dmmaddro SHALL equal dmmaddri, all combinational with zero latency.
REQ-021 dmmstoreo and dmmloado SHALL be combinational functions of cuOP, dmmaddri[1:0] and the data inputs (see Configuration).
REQ-022 Changes of cuOP while a request is pending (i_ready=0) SHALL NOT alter dmmRen/dmmWen.

Reset
REQ-023 When nRST=0 at a rising CLK, dmmRen and dmmWen SHALL be 0 after that edge, overriding i_ready and d_ready; imemRen is then 1.
REQ-024 Reset asserted mid-request SHALL abort the request (dmmRen/dmmWen to 0 on that edge).
REQ-025 Combinational data/address outputs SHALL NOT depend on nRST.

Configuration
REQ-026 Macro REQUEST_UNIT_SUBWORD_EN SHALL control sub-word data handling.
REQ-027 With the macro defined: CU_SB drives dmmstoreo with dmmstorei[7:0] replicated 4 times; CU_SH drives dmmstorei[15:0] replicated twice; all other ops pass dmmstorei.
REQ-028 With the macro defined: CU_LB/CU_LBU select byte dmmaddri[1:0] of dmmloadi, sign-/zero-extended; CU_LH/CU_LHU select halfword dmmaddri[1] (bit 0 ignored), sign-/zero-extended; all other ops pass dmmloadi.
REQ-029 Without the macro: dmmstoreo SHALL equal dmmstorei and dmmloado SHALL equal dmmloadi for every cuOP.

Verification
REQ-030 nRST=0 two cycles, cuOP=CU_LH, i_ready=0, d_ready=0 -> dmmRen=0, dmmWen=0, imemRen=1.
REQ-031 nRST=1, i_ready=1, cuOP=CU_LB, dmmaddri=0x00010001, imemaddri=0x12341234 -> after one edge dmmRen=1, dmmWen=0, imemRen=0, dmmaddro=0x00010001, imemaddro=0x12341234.
REQ-032 Then i_ready=0, d_ready=1, cuOP=CU_LH -> after one edge dmmRen=0, dmmWen=0, imemRen=1.
REQ-033 i_ready=1, d_ready=0, cuOP=CU_SW, dmmstorei=0xDACBDACB -> after one edge dmmWen=1, dmmRen=0, dmmstoreo=0xDACBDACB; then d_ready=1 -> both 0 next edge.
REQ-034 i_ready=1 and d_ready=1 together with cuOP=CU_LW -> both requests 0 after the edge.
REQ-035 Macro defined: CU_LB, dmmaddri[1:0]=01, dmmloadi=0x000080FF -> dmmloado=0xFFFFFF80; CU_LBU -> 0x00000080; CU_SB, dmmstorei=0xABCDABCD -> dmmstoreo=0xCDCDCDCD.

Source files
------------

// File: rtl/request_unit.sv
// Memory request unit: registers data read/write requests and gates instruction fetch.
// Optional sub-word load/store steering is enabled by defining REQUEST_UNIT_SUBWORD_EN.

package request_unit_pkg;
    typedef enum logic [5:0] {
        CU_NOP,
        CU_LUI,
        CU_AUIPC,
        CU_JAL,
        CU_JALR,
        CU_BEQ,
        CU_BNE,
        CU_BLT,
        CU_BGE,
        CU_BLTU,
        CU_BGEU,
        CU_LB,
        CU_LH,
        CU_LW,
        CU_LBU,
        CU_LHU,
        CU_SB,
        CU_SH,
        CU_SW,
        CU_ADDI,
        CU_SLTI,
        CU_SLTIU,
        CU_XORI,
        CU_ORI,
        CU_ANDI,
        CU_SLLI,
        CU_SRLI,
        CU_SRAI,
        CU_ADD,
        CU_SUB,
        CU_SLL,
        CU_SLT,
        CU_SLTU,
        CU_XOR,
        CU_SRL,
        CU_SRA,
        CU_OR,
        CU_AND,
        CU_HALT
    } cuOPType;
endpackage

module request_unit
    import request_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_ready,
    input  logic        d_ready,
    input  cuOPType     cuOP,
    input  logic [31:0] dmmstorei,
    input  logic [31:0] dmmaddri,
    input  logic [31:0] imemaddri,
    input  logic [31:0] imemloadi,
    input  logic [31:0] dmmloadi,
    output logic        dmmRen,
    output logic        dmmWen,
    output logic        imemRen,
    output logic [31:0] dmmstoreo,
    output logic [31:0] dmmaddro,
    output logic [31:0] imemaddro,
    output logic [31:0] imemloado,
    output logic [31:0] dmmloado
);

    // One-hot request encoding: each request output is a flop bit, and
    // the two can never be set together.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_is_load;
    logic   w_is_store;

    assign w_is_load  = (cuOP inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU});
    assign w_is_store = (cuOP inside {CU_SB, CU_SH, CU_SW});

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Data completion has priority over a new instruction being presented.
    always_comb begin
        w_next = r_state;
        if (d_ready) begin
            w_next = ST_IDLE;
        end else if (i_ready) begin
            if (w_is_load) begin
                w_next = ST_READ;
            end else if (w_is_store) begin
                w_next = ST_WRITE;
            end else begin
                w_next = ST_IDLE;
            end
        end
    end

    assign dmmRen  = r_state[0];
    assign dmmWen  = r_state[1];
    assign imemRen = ~(r_state[0] | r_state[1]);

    assign imemaddro = imemaddri;
    assign imemloado = imemloadi;
    assign dmmaddro  = dmmaddri;

`ifdef REQUEST_UNIT_SUBWORD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (dmmaddri[1:0])
            2'b00:   w_byte = dmmloadi[7:0];
            2'b01:   w_byte = dmmloadi[15:8];
            2'b10:   w_byte = dmmloadi[23:16];
            default: w_byte = dmmloadi[31:24];
        endcase
        w_half = dmmaddri[1] ? dmmloadi[31:16] : dmmloadi[15:0];
    end

    always_comb begin
        dmmstoreo = dmmstorei;
        dmmloado  = dmmloadi;
        case (cuOP)
            CU_SB:   dmmstoreo = {4{dmmstorei[7:0]}};
            CU_SH:   dmmstoreo = {2{dmmstorei[15:0]}};
            default: dmmstoreo = dmmstorei;
        endcase
        case (cuOP)
            CU_LB:   dmmloado = {{24{w_byte[7]}}, w_byte};
            CU_LBU:  dmmloado = {24'h000000, w_byte};
            CU_LH:   dmmloado = {{16{w_half[15]}}, w_half};
            CU_LHU:  dmmloado = {16'h0000, w_half};
            default: dmmloado = dmmloadi;
        endcase
    end
`else
    assign dmmstoreo = dmmstorei;
    assign dmmloado  = dmmloadi;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Directed + randomized scoreboard bench for request_unit; expectations come
// from a behavioural model evaluated when each step's stimulus is driven.

module tb_request_unit;
    import request_unit_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        i_ready;
    logic        d_ready;
    cuOPType     cuOP;
    logic [31:0] dmmstorei;
    logic [31:0] dmmaddri;
    logic [31:0] imemaddri;
    logic [31:0] imemloadi;
    logic [31:0] dmmloadi;
    logic        dmmRen;
    logic        dmmWen;
    logic        imemRen;
    logic [31:0] dmmstoreo;
    logic [31:0] dmmaddro;
    logic [31:0] imemaddro;
    logic [31:0] imemloado;
    logic [31:0] dmmloado;

    request_unit dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_ready   (i_ready),
        .d_ready   (d_ready),
        .cuOP      (cuOP),
        .dmmstorei (dmmstorei),
        .dmmaddri  (dmmaddri),
        .imemaddri (imemaddri),
        .imemloadi (imemloadi),
        .dmmloadi  (dmmloadi),
        .dmmRen    (dmmRen),
        .dmmWen    (dmmWen),
        .imemRen   (imemRen),
        .dmmstoreo (dmmstoreo),
        .dmmaddro  (dmmaddro),
        .imemaddro (imemaddro),
        .imemloado (imemloado),
        .dmmloado  (dmmloado)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren;
        logic        wen;
        logic        iren;
        logic [31:0] storeo;
        logic [31:0] loado;
        logic [31:0] daddr;
        logic [31:0] iaddr;
        logic [31:0] iload;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic m_ren    = 1'b0;
    logic m_wen    = 1'b0;

    function automatic logic is_load(input cuOPType op);
        return op == CU_LB || op == CU_LH || op == CU_LW || op == CU_LBU || op == CU_LHU;
    endfunction

    function automatic logic is_store(input cuOPType op);
        return op == CU_SB || op == CU_SH || op == CU_SW;
    endfunction

    function automatic logic [31:0] mdl_store(input cuOPType op, input logic [31:0] d);
`ifdef REQUEST_UNIT_SUBWORD_EN
        if (op == CU_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (op == CU_SH) return {d[15:0], d[15:0]};
`endif
        return d;
    endfunction

    function automatic logic [31:0] mdl_load(input cuOPType op, input logic [1:0] a,
                                             input logic [31:0] d);
`ifdef REQUEST_UNIT_SUBWORD_EN
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'h0000_00FF;
        h = (d >> (16 * a[1])) & 32'h0000_FFFF;
        case (op)
            CU_LB:   return b[7] ? (b | 32'hFFFF_FF00) : b;
            CU_LBU:  return b;
            CU_LH:   return h[15] ? (h | 32'hFFFF_0000) : h;
            CU_LHU:  return h;
            default: return d;
        endcase
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model across the coming edge, push its prediction, then
    // pop and compare once the DUT has taken that edge.
    task automatic step(input string tag);
        exp_t e;
        exp_t g;
        if (!nRST) begin
            m_ren = 1'b0;
            m_wen = 1'b0;
        end else if (d_ready) begin
            m_ren = 1'b0;
            m_wen = 1'b0;
        end else if (i_ready) begin
            m_ren = is_load(cuOP);
            m_wen = is_store(cuOP);
        end
        e.ren    = m_ren;
        e.wen    = m_wen;
        e.iren   = !(m_ren || m_wen);
        e.storeo = mdl_store(cuOP, dmmstorei);
        e.loado  = mdl_load(cuOP, dmmaddri[1:0], dmmloadi);
        e.daddr  = dmmaddri;
        e.iaddr  = imemaddri;
        e.iload  = imemloadi;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        chk({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            g = sb.pop_front();
            chk({tag, ".dmmRen"},    {31'b0, dmmRen},  {31'b0, g.ren});
            chk({tag, ".dmmWen"},    {31'b0, dmmWen},  {31'b0, g.wen});
            chk({tag, ".imemRen"},   {31'b0, imemRen}, {31'b0, g.iren});
            chk({tag, ".dmmstoreo"}, dmmstoreo, g.storeo);
            chk({tag, ".dmmloado"},  dmmloado,  g.loado);
            chk({tag, ".dmmaddro"},  dmmaddro,  g.daddr);
            chk({tag, ".imemaddro"}, imemaddro, g.iaddr);
            chk({tag, ".imemloado"}, imemloado, g.iload);
        end
    endtask

    cuOPType ops[12] = '{CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB,
                         CU_SH, CU_SW, CU_ADD, CU_NOP, CU_JAL, CU_ORI};

    initial begin
        nRST      = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        cuOP      = CU_LH;
        dmmstorei = 32'h0;
        dmmaddri  = 32'h0;
        imemaddri = 32'h0;
        imemloadi = 32'h0;
        dmmloadi  = 32'h0;

        step("reset0");
        step("reset1");

        nRST = 1'b1; i_ready = 1'b1; cuOP = CU_LB;
        dmmaddri = 32'h0001_0001; imemaddri = 32'h1234_1234; imemloadi = 32'h0000_0013;
        step("lb_req");

        i_ready = 1'b0; d_ready = 1'b1; cuOP = CU_LH;
        step("lb_done");

        i_ready = 1'b1; d_ready = 1'b0; cuOP = CU_SW; dmmstorei = 32'hDACB_DACB;
        step("sw_req");
        i_ready = 1'b0; d_ready = 1'b1;
        step("sw_done");

        i_ready = 1'b1; d_ready = 1'b1; cuOP = CU_LW;
        step("both_ready");

        d_ready = 1'b0;
        step("lw_req");
        i_ready = 1'b0; cuOP = CU_SW;
        step("hold_op_change");
        cuOP = CU_ADD;
        step("hold_nonmem");

        i_ready = 1'b1; cuOP = CU_ADD;
        step("nonmem_clear");

        cuOP = CU_SB;
        step("sb_req");
        nRST = 1'b0;
        step("reset_abort");
        nRST = 1'b1; i_ready = 1'b0; d_ready = 1'b0;
        step("after_abort");

        i_ready = 1'b0; d_ready = 1'b0;
        dmmaddri = 32'h0000_0001; dmmloadi = 32'h0000_80FF; cuOP = CU_LB;
        step("lb_byte1");
        cuOP = CU_LBU;
        step("lbu_byte1");
        cuOP = CU_SB; dmmstorei = 32'hABCD_ABCD;
        step("sb_repl");
        cuOP = CU_SH; dmmstorei = 32'h1234_8765;
        step("sh_repl");
        cuOP = CU_LH; dmmaddri = 32'h0000_0003; dmmloadi = 32'h9ABC_0011;
        step("lh_hi");
        cuOP = CU_LHU;
        step("lhu_hi");
        cuOP = CU_LB; dmmaddri = 32'h0000_0000; dmmloadi = 32'h1122_3344;
        step("lb_byte0");

        for (int k = 0; k < 40; k++) begin
            nRST      = ($urandom_range(0, 15) != 0);
            i_ready   = 1'($urandom_range(0, 1));
            d_ready   = ($urandom_range(0, 3) == 0);
            cuOP      = ops[$urandom_range(0, 11)];
            dmmstorei = $urandom;
            dmmaddri  = $urandom;
            imemaddri = $urandom;
            imemloadi = $urandom;
            dmmloadi  = $urandom;
            step($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
